// File: rtl/wbq_pkg.sv
// Shared definitions for the register-file writeback queue: default depth,
// protected register indices and the queued {addr, data} entry record.
package wbq_pkg;

  localparam int WBQ_DEPTH = 4;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_K0   = 5'd26;
  localparam logic [4:0] REG_K1   = 5'd27;

  typedef struct packed {
    logic        [4:0]  addr;
    logic signed [31:0] data;
  } wbq_entry_t;

endpackage

// File: rtl/wbq_match.sv
// Youngest-match search over the live window of the circular queue; entries are
// walked oldest to youngest so the last match seen wins.
module wbq_match
  import wbq_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH
) (
  input  wbq_entry_t [DEPTH-1:0]         i_entries,
  input  logic [$clog2(DEPTH)-1:0]       i_head,
  input  logic [$clog2(DEPTH):0]         i_count,
  input  logic [4:0]                     i_query,
  output logic                           o_hit,
  output logic signed [31:0]             o_data
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] w_idx;

  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = i_head + PW'(i);
      if (((PW+1)'(i) < i_count) && (i_query != REG_ZERO) &&
          (i_entries[w_idx].addr == i_query)) begin
        o_hit  = 1'b1;
        o_data = i_entries[w_idx].data;
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// Circular writeback queue between the pipeline and the register-file write
// port, with two read-bypass query ports over the queued entries.
module writeback_queue
  import wbq_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic [4:0]                InAddr,
  input  logic signed [31:0]        InData,
  input  logic                      Stall,
  output logic                      RegWrite,
  output logic [4:0]                WAddr,
  output logic signed [31:0]        WData,
  input  logic [4:0]                QAddr1,
  input  logic [4:0]                QAddr2,
  output logic                      Hit1,
  output logic                      Hit2,
  output logic signed [31:0]        FwdData1,
  output logic signed [31:0]        FwdData2,
  output logic [$clog2(DEPTH):0]    Count,
  output logic                      Full,
  output logic                      Empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  wbq_entry_t [DEPTH-1:0] r_mem;
  logic [PW-1:0]          r_head;
  logic [PW-1:0]          r_tail;
  logic [PW:0]            r_count;

  logic w_full, w_empty, w_protected, w_push, w_pop;

  assign w_full      = (r_count == FULL_CNT);
  assign w_empty     = (r_count == '0);
  assign w_protected = (InAddr == REG_ZERO) || (InAddr == REG_K0) || (InAddr == REG_K1);
  // A full queue still accepts when the head drains in the same cycle.
  assign InReady     = !w_full || !Stall;
  assign w_pop       = !w_empty && !Stall;
  // Protected indices complete the handshake but are dropped here.
  assign w_push      = InValid && InReady && !w_protected;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is validated by the pointers alone, so it carries no reset.
  always_ff @(posedge Clk) begin
    if (w_push) r_mem[r_tail] <= '{addr: InAddr, data: InData};
  end

  assign RegWrite = w_pop;
  assign WAddr    = w_empty ? 5'd0  : r_mem[r_head].addr;
  assign WData    = w_empty ? 32'sd0 : r_mem[r_head].data;
  assign Count    = r_count;
  assign Full     = w_full;
  assign Empty    = w_empty;

  wbq_match #(.DEPTH(DEPTH)) u_match1 (
    .i_entries (r_mem),
    .i_head    (r_head),
    .i_count   (r_count),
    .i_query   (QAddr1),
    .o_hit     (Hit1),
    .o_data    (FwdData1)
  );

  wbq_match #(.DEPTH(DEPTH)) u_match2 (
    .i_entries (r_mem),
    .i_head    (r_head),
    .i_count   (r_count),
    .i_query   (QAddr2),
    .o_hit     (Hit2),
    .o_data    (FwdData2)
  );

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: a reference queue of {addr, data} is
// advanced every cycle and every output is compared against it.
module tb_writeback_queue;

  localparam int DEPTH = 4;

  logic               Clk = 1'b0;
  logic               Reset;
  logic               InValid;
  logic               InReady;
  logic [4:0]         InAddr;
  logic signed [31:0] InData;
  logic               Stall;
  logic               RegWrite;
  logic [4:0]         WAddr;
  logic signed [31:0] WData;
  logic [4:0]         QAddr1, QAddr2;
  logic               Hit1, Hit2;
  logic signed [31:0] FwdData1, FwdData2;
  logic [2:0]         Count;
  logic               Full, Empty;

  int n_cmp = 0;
  int n_err = 0;
  logic [36:0] sb[$];

  writeback_queue #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InAddr(InAddr), .InData(InData), .Stall(Stall), .RegWrite(RegWrite),
    .WAddr(WAddr), .WData(WData), .QAddr1(QAddr1), .QAddr2(QAddr2),
    .Hit1(Hit1), .Hit2(Hit2), .FwdData1(FwdData1), .FwdData2(FwdData2),
    .Count(Count), .Full(Full), .Empty(Empty)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] model_fwd(input logic [4:0] q);
    logic [32:0] r;
    r = '0;
    if (q != 5'd0)
      foreach (sb[i]) if (sb[i][36:32] == q) r = {1'b1, sb[i][31:0]};
    return r;
  endfunction

  // One cycle: apply inputs after the falling edge, check outputs, advance model.
  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic st, input logic [4:0] q1, input logic [4:0] q2);
    logic exp_empty, exp_full, exp_ready, exp_pop, prot;
    logic [32:0] f1, f2;
    @(negedge Clk);
    InValid = v; InAddr = a; InData = d; Stall = st; QAddr1 = q1; QAddr2 = q2;
    #1;
    exp_empty = (sb.size() == 0);
    exp_full  = (sb.size() == DEPTH);
    exp_ready = !exp_full || !st;
    exp_pop   = !exp_empty && !st;
    prot      = (a == 5'd0) || (a == 5'd26) || (a == 5'd27);
    f1 = model_fwd(q1);
    f2 = model_fwd(q2);
    check("count",    32'(Count),    32'(sb.size()));
    check("full",     32'(Full),     32'(exp_full));
    check("empty",    32'(Empty),    32'(exp_empty));
    check("inready",  32'(InReady),  32'(exp_ready));
    check("regwrite", 32'(RegWrite), 32'(exp_pop));
    check("waddr",    32'(WAddr),    exp_empty ? 32'd0 : 32'(sb[0][36:32]));
    check("wdata",    WData,         exp_empty ? 32'd0 : sb[0][31:0]);
    check("hit1",     32'(Hit1),     32'(f1[32]));
    check("fwd1",     FwdData1,      f1[31:0]);
    check("hit2",     32'(Hit2),     32'(f2[32]));
    check("fwd2",     FwdData2,      f2[31:0]);
    if (exp_pop) void'(sb.pop_front());
    if (v && exp_ready && !prot) sb.push_back({a, d});
  endtask

  task automatic do_reset(input logic st);
    @(negedge Clk);
    Reset = 1'b1; InValid = 1'b0; Stall = st;
    @(negedge Clk);
    Reset = 1'b0;
    sb.delete();
  endtask

  initial begin
    logic [4:0] ra;
    Reset = 1'b1; InValid = 1'b0; InAddr = '0; InData = '0; Stall = 1'b0;
    QAddr1 = '0; QAddr2 = '0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;

    // Post-reset state, including a zero query that must never hit.
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5);

    // Single write with one-cycle latency, then empty again.
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd5, 5'd0);
    drive(1'b0, 5'd0, 32'd0,    1'b0, 5'd5, 5'd0);
    drive(1'b0, 5'd0, 32'd0,    1'b0, 5'd5, 5'd0);

    // Fill under stall, blocked push, then push alongside a pop at full.
    for (int i = 0; i < 4; i++)
      drive(1'b1, 5'(i + 1), 32'(100 + i), 1'b1, 5'd2, 5'd4);
    drive(1'b1, 5'd20, 32'hDEAD, 1'b1, 5'd1, 5'd20);
    drive(1'b1, 5'd6,  32'hBEEF, 1'b0, 5'd6, 5'd1);
    drive(1'b0, 5'd0,  32'd0,    1'b1, 5'd6, 5'd1);
    for (int i = 0; i < 5; i++) drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd6, 5'd3);

    // Protected destinations complete the handshake and are dropped.
    drive(1'b1, 5'd0,  32'h11, 1'b0, 5'd26, 5'd27);
    drive(1'b1, 5'd26, 32'h22, 1'b0, 5'd26, 5'd27);
    drive(1'b1, 5'd27, 32'h33, 1'b0, 5'd26, 5'd27);
    drive(1'b0, 5'd0,  32'd0,  1'b0, 5'd26, 5'd27);

    // Bypass picks the youngest of two matching entries.
    drive(1'b1, 5'd9, 32'd10,         1'b1, 5'd9, 5'd3);
    drive(1'b1, 5'd9, 32'd20,         1'b1, 5'd9, 5'd3);
    drive(1'b1, 5'd3, 32'hFFFF_FFF0,  1'b1, 5'd9, 5'd4);
    drive(1'b0, 5'd0, 32'd0,          1'b1, 5'd9, 5'd3);
    drive(1'b0, 5'd0, 32'd0,          1'b1, 5'd9, 5'd31);
    for (int i = 0; i < 4; i++) drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd9, 5'd3);

    // Wrap-around with random stall; order is checked at every drain.
    for (int i = 0; i < 10; i++) begin
      ra = 5'($urandom_range(1, 25));
      drive(1'b1, ra, $urandom, 1'($urandom_range(0, 1)), ra, 5'($urandom_range(0, 31)));
    end
    for (int i = 0; i < 6; i++) drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd8);

    // Reset while entries are queued: nothing stale drains afterwards.
    for (int i = 0; i < 3; i++) drive(1'b1, 5'(12 + i), 32'(500 + i), 1'b1, 5'd12, 5'd14);
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd12, 5'd14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: Clk (clock) and Reset (active-high synchronous reset).
REQ-002 The module SHALL have parameter DEPTH, default 4, giving the number of queue entries (a power of two, at least 2).
REQ-003 Port Clk SHALL be an input, 1 bit wide: the system clock; all state updates on posedge.
REQ-004 Port Reset SHALL be an input, 1 bit wide: synchronous active-high clear.
REQ-005 Port InValid SHALL be an input, 1 bit wide: the pipeline presents a write request.
REQ-006 Port InReady SHALL be an output, 1 bit wide: the queue can accept a request this cycle.
REQ-007 Port InAddr SHALL be an input, 5 bits wide: the destination register index.
REQ-008 Port InData SHALL be an input, 32 bits wide: signed write data.
REQ-009 Port Stall SHALL be an input, 1 bit wide: when high, the register-file write port is unavailable and no drain occurs.
REQ-010 Ports RegWrite (1 bit), WAddr (5 bits) and WData (32 bits) SHALL be outputs that drive the register-file write port.
REQ-011 Ports QAddr1 and QAddr2 SHALL be inputs, 5 bits each: register indices for read-bypass queries.
REQ-012 Ports Hit1 and Hit2 SHALL be outputs, 1 bit each, and FwdData1 and FwdData2 SHALL be outputs, 32 bits each: the bypass result.
REQ-013 Port Count SHALL be an output, clog2(DEPTH)+1 bits wide; ports Full and Empty SHALL be 1-bit outputs.

Function
REQ-014 The queue SHALL be a circular FIFO of {addr, data} entries with head and tail pointers that wrap modulo DEPTH.
REQ-015 A push SHALL occur when InValid && InReady && InAddr is not 0, 26 or 27; the entry is stored at tail at the posedge.
REQ-016 A request with InAddr equal to 0, 26 or 27 SHALL be accepted (handshake completes) but discarded: no enqueue, Count unchanged.
REQ-017 A pop SHALL occur at a posedge when !Empty && !Stall; the head advances by one.
REQ-018 InReady SHALL equal !Full || !Stall, so a push into a full queue is permitted only when a simultaneous pop occurs.
REQ-019 A simultaneous push and pop SHALL leave Count unchanged; push alone adds 1; pop alone subtracts 1.
REQ-020 RegWrite SHALL be combinational and equal !Empty && !Stall.
REQ-021 WAddr and WData SHALL show the head entry when !Empty, and 0 when Empty.
REQ-022 A request pushed at posedge N SHALL appear on the write port no earlier than cycle N+1; latency through an empty, unstalled queue is exactly 1 cycle.
REQ-023 Hit_k SHALL be 1 when any stored entry's addr equals QAddr_k; a QAddr_k of 0 SHALL never hit.
REQ-024 FwdData_k SHALL be the data of the youngest matching entry (the one closest to tail), and 0 when there is no hit.
REQ-025 The bypass SHALL consider only stored entries; a request being presented in the same cycle is not forwarded.
REQ-026 Full SHALL be (Count == DEPTH), and Empty SHALL be (Count == 0).

Reset
REQ-027 While Reset is high at a posedge, head, tail and Count SHALL go to 0, and any pending push or pop SHALL be ignored.
REQ-028 After reset: Empty=1, Full=0, InReady=1, RegWrite=0, WAddr=0, WData=0, Hit1=Hit2=0, FwdData1=FwdData2=0.
REQ-029 A reset asserted mid-drain SHALL discard all queued entries; no further RegWrite pulses occur for them.
REQ-030 Entry storage contents need not be cleared on reset; validity derives from the pointers only.

Structure
REQ-031 A shared package SHALL hold the DEPTH default, the constants REG_ZERO=0, REG_K0=26 and REG_K1=27, and the entry record type {addr[4:0], data[31:0]}.
REQ-032 The youngest-match priority search SHALL be one sub-module, wbq_match, instantiated twice (once per query port).

Verification
REQ-033 Single write: Reset, then push (5, 0x1234) with Stall=0 -> the next cycle shows RegWrite=1, WAddr=5, WData=0x1234, and Empty follows.
REQ-034 Fill under stall: Stall=1, push 4 entries -> Full=1 and InReady=0; a 5th push with Stall=0 completes alongside a pop, and Count stays 4.
REQ-035 Protected addresses: push addresses 0, 26 and 27 -> InReady handshake completes, Count stays 0, and RegWrite never rises.
REQ-036 Bypass: Stall=1, push (9, 10) then (9, 20); QAddr1=9 -> Hit1=1, FwdData1=20; QAddr2=3 -> Hit2=0, FwdData2=0.
REQ-037 Wrap-around: 10 push/pop cycles with DEPTH=4 and random Stall -> the drain order matches the push order exactly.
REQ-038 Reset mid-operation: 3 entries queued under Stall=1, assert Reset -> Count=0, RegWrite=0, and no stale write follows.
